// File: rtl/oisc_mem_arbiter_pkg.sv
// Shared encodings and width defaults for the OISC memory arbiter.
// State and owner codes are fixed so external debug/trace tooling can decode them.
package oisc_mem_arbiter_pkg;

   localparam int GPR_WIDTH         = 32;
   localparam int INSTRUCTION_WIDTH = 32;
   localparam int ADDR_WIDTH        = 32;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ISSUE   = 2'd1,
      ST_WAIT    = 2'd2,
      ST_DELIVER = 2'd3
   } state_t;

   typedef enum logic {
      OWN_FETCH = 1'b0,
      OWN_DATA  = 1'b1
   } owner_t;

   function automatic owner_t other_owner(input owner_t o);
      return (o == OWN_FETCH) ? OWN_DATA : OWN_FETCH;
   endfunction

endpackage

// File: rtl/oisc_rr_pick.sv
// Two-way round-robin selector: a lone requester wins, a tie goes to
// whichever side was not granted last.
module oisc_rr_pick
   import oisc_mem_arbiter_pkg::*;
(
   input  logic   fetch_valid,
   input  logic   data_valid,
   input  owner_t last_grant,
   output logic   grant,
   output owner_t owner
);

   always_comb begin
      grant = fetch_valid | data_valid;
      owner = OWN_FETCH;
      if (fetch_valid && data_valid) begin
         owner = other_owner(last_grant);
      end else if (data_valid) begin
         owner = OWN_DATA;
      end
   end

endmodule

// File: rtl/oisc_mem_arbiter.sv
// Single-port memory arbiter between OISC instruction fetch and MMU data paths.
// One transaction in flight: accept -> issue -> wait -> deliver; base+offset carry errors skip memory.
module oisc_mem_arbiter
   import oisc_mem_arbiter_pkg::*;
#(
   parameter int DW = GPR_WIDTH,
   parameter int AW = ADDR_WIDTH,
   parameter int IW = INSTRUCTION_WIDTH
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          FetchReqValid,
   output logic          FetchReqReady,
   input  logic [AW-1:0] FetchAddr,
   output logic          FetchRspValid,
   input  logic          FetchRspReady,
   output logic [IW-1:0] FetchRspData,
   input  logic          DataReqValid,
   output logic          DataReqReady,
   input  logic [AW-1:0] DataBase,
   input  logic [AW-1:0] DataOffset,
   input  logic [DW-1:0] DataWData,
   input  logic          DataWrite,
   output logic          DataRspValid,
   input  logic          DataRspReady,
   output logic [DW-1:0] DataRspData,
   output logic          DataRspErr,
   output logic          MemReqValid,
   input  logic          MemReqReady,
   output logic [AW-1:0] MemAddr,
   output logic [DW-1:0] MemWData,
   output logic          MemWrite,
   input  logic          MemRspValid,
   output logic          MemRspReady,
   input  logic [DW-1:0] MemRData
);

   state_t        state;
   state_t        state_nxt;
   owner_t        owner_q;
   owner_t        last_grant;
   owner_t        pick_owner;
   logic          pick_grant;
   logic          accept;
   logic [AW:0]   data_sum;
   logic          data_ovf;
   logic [AW-1:0] addr_q;
   logic [DW-1:0] wdata_q;
   logic          write_q;
   logic [DW-1:0] rsp_data_q;
   logic          rsp_err_q;

   oisc_rr_pick u_rr_pick (
      .fetch_valid (FetchReqValid),
      .data_valid  (DataReqValid),
      .last_grant  (last_grant),
      .grant       (pick_grant),
      .owner       (pick_owner)
   );

   // One extra bit so the carry out of base+offset is visible.
   assign data_sum = {1'b0, DataBase} + {1'b0, DataOffset};
   assign data_ovf = data_sum[AW];

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      accept        = 1'b0;
      FetchReqReady = 1'b0;
      DataReqReady  = 1'b0;
      MemReqValid   = 1'b0;
      MemRspReady   = 1'b0;
      FetchRspValid = 1'b0;
      DataRspValid  = 1'b0;
      case (state)
         ST_IDLE: begin
            FetchReqReady = pick_grant && (pick_owner == OWN_FETCH);
            DataReqReady  = pick_grant && (pick_owner == OWN_DATA);
            accept        = pick_grant;
            if (pick_grant) begin
               state_nxt = ((pick_owner == OWN_DATA) && data_ovf) ? ST_DELIVER : ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            MemReqValid = 1'b1;
            if (MemReqReady) begin
               state_nxt = ST_WAIT;
            end
         end
         ST_WAIT: begin
            MemRspReady = 1'b1;
            if (MemRspValid) begin
               state_nxt = ST_DELIVER;
            end
         end
         ST_DELIVER: begin
            if (owner_q == OWN_FETCH) begin
               FetchRspValid = 1'b1;
               if (FetchRspReady) begin
                  state_nxt = ST_IDLE;
               end
            end else begin
               DataRspValid = 1'b1;
               if (DataRspReady) begin
                  state_nxt = ST_IDLE;
               end
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         owner_q    <= OWN_FETCH;
         last_grant <= OWN_FETCH;
         addr_q     <= '0;
         wdata_q    <= '0;
         write_q    <= 1'b0;
         rsp_data_q <= '0;
         rsp_err_q  <= 1'b0;
      end else if (accept) begin
         owner_q    <= pick_owner;
         last_grant <= pick_owner;
         rsp_data_q <= '0;
         if (pick_owner == OWN_DATA) begin
            addr_q    <= data_sum[AW-1:0];
            wdata_q   <= DataWData;
            write_q   <= DataWrite;
            rsp_err_q <= data_ovf;
         end else begin
            addr_q    <= FetchAddr;
            wdata_q   <= '0;
            write_q   <= 1'b0;
            rsp_err_q <= 1'b0;
         end
      end else if ((state == ST_WAIT) && MemRspValid) begin
         // Writes still get a memory response, but return zero data to the MMU.
         rsp_data_q <= write_q ? '0 : MemRData;
      end
   end

   assign MemAddr      = addr_q;
   assign MemWData     = wdata_q;
   assign MemWrite     = write_q;
   assign FetchRspData = rsp_data_q[IW-1:0];
   assign DataRspData  = rsp_data_q;
   assign DataRspErr   = DataRspValid & rsp_err_q;

endmodule
